// File: rtl/hex_seq_game_if.sv
// rtl/hex_seq_game_if.sv - alarm/switch/display bundle for the hex sequence puzzle
interface hex_seq_game_if #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int IDX_W  = $clog2(N_DIGITS + 1);
    localparam int MISS_W = $clog2(MAX_TRIES + 1);

    logic                game_Ena;
    logic [DIGIT_W-1:0]  user_Inp;
    logic                enter_Pulse;
    logic                tick_1Hz;
    logic                ext_Disp_On;
    logic [DIGIT_W-1:0]  hex_Num_Sel;
    logic [IDX_W-1:0]    digit_Idx;
    logic [MISS_W-1:0]   miss_Cnt;
    logic                puzzle_Solved;

    modport master (
        output game_Ena, user_Inp, enter_Pulse, tick_1Hz,
        input  ext_Disp_On, hex_Num_Sel, digit_Idx, miss_Cnt, puzzle_Solved
    );

    modport slave (
        input  game_Ena, user_Inp, enter_Pulse, tick_1Hz,
        output ext_Disp_On, hex_Num_Sel, digit_Idx, miss_Cnt, puzzle_Solved
    );
endinterface

// File: rtl/hex_seq_game.sv
// rtl/hex_seq_game.sv - N-digit hex sequence puzzle with LFSR targets and cooldown
// Optional HEX_SEQ_GAME_RESEED_EN: relatch fresh targets after MAX_TRIES misses.
module hex_seq_game #(
    parameter int                N_DIGITS   = 4,
    parameter int                DIGIT_W    = 4,
    parameter int                LFSR_W     = 32,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(64'hACE1_5EED),
    parameter int                MAX_TRIES  = 3,
    parameter int                COOLDOWN_S = 60
) (
    input  logic          clk,
    input  logic          rst,
    hex_seq_game_if.slave bus
);
    localparam int IDX_W  = $clog2(N_DIGITS + 1);
    localparam int MISS_W = $clog2(MAX_TRIES + 1);
    localparam int COOL_W = $clog2(COOLDOWN_S + 1);
    localparam int TGT_W  = N_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_SOLVED
    } state_t;

    // Right-shifting Galois masks for maximal-length sequences.
    function automatic logic [LFSR_W-1:0] lfsr_taps(input int w);
        case (w)
            8:       return LFSR_W'(64'h0000_00B8);
            16:      return LFSR_W'(64'h0000_B400);
            24:      return LFSR_W'(64'h00E1_0000);
            default: return LFSR_W'(64'h8020_0003);
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = lfsr_taps(LFSR_W);

    function automatic logic [DIGIT_W-1:0] pick(input logic [TGT_W-1:0] v,
                                                input logic [IDX_W-1:0] idx);
        pick = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) pick = v[k*DIGIT_W +: DIGIT_W];
        end
    endfunction

    state_t              r_state, w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
    logic [TGT_W-1:0]    r_tgt, w_tgt_nxt, w_fresh;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [COOL_W-1:0]   r_cool, w_cool_nxt;
    logic                r_disp, w_disp_nxt;
    logic                r_solved, w_solved_nxt;
    logic [DIGIT_W-1:0]  r_hex, w_hex_nxt;
    logic [DIGIT_W-1:0]  w_cur;
    logic                w_match;

    always_comb begin
        w_fresh = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_lfsr[k*DIGIT_W +: DIGIT_W] == '0)
                w_fresh[k*DIGIT_W +: DIGIT_W] = '1;
            else
                w_fresh[k*DIGIT_W +: DIGIT_W] = r_lfsr[k*DIGIT_W +: DIGIT_W];
        end
    end

    assign w_cur   = pick(r_tgt, r_idx);
    assign w_match = (bus.user_Inp == w_cur);

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        w_tgt_nxt   = r_tgt;
        w_idx_nxt   = r_idx;
        w_miss_nxt  = r_miss;
        w_cool_nxt  = r_cool;

        case (r_state)
            S_IDLE: begin
                if (bus.game_Ena) begin
                    w_tgt_nxt   = w_fresh;
                    w_idx_nxt   = '0;
                    w_miss_nxt  = '0;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // Losing game_Ena wins over a same-cycle confirm.
                if (!bus.game_Ena) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (bus.enter_Pulse) begin
                    if (w_match) begin
                        if (r_idx == IDX_W'(N_DIGITS - 1)) begin
                            w_idx_nxt   = '0;
                            w_cool_nxt  = '0;
                            w_state_nxt = S_SOLVED;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_idx_nxt = '0;
`ifdef HEX_SEQ_GAME_RESEED_EN
                        if (r_miss == MISS_W'(MAX_TRIES - 1)) begin
                            w_tgt_nxt  = w_fresh;
                            w_miss_nxt = '0;
                        end else begin
                            w_miss_nxt = r_miss + MISS_W'(1);
                        end
`else
                        if (r_miss != MISS_W'(MAX_TRIES))
                            w_miss_nxt = r_miss + MISS_W'(1);
`endif
                    end
                end
            end
            S_SOLVED: begin
                if (bus.tick_1Hz) begin
                    if (r_cool == COOL_W'(COOLDOWN_S - 1)) begin
                        w_cool_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cool_nxt = r_cool + COOL_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_disp_nxt   = (w_state_nxt == S_PLAY);
        w_solved_nxt = (w_state_nxt == S_SOLVED);
        w_hex_nxt    = (w_state_nxt == S_PLAY) ? pick(w_tgt_nxt, w_idx_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= SEED;
            r_tgt    <= '0;
            r_idx    <= '0;
            r_miss   <= '0;
            r_cool   <= '0;
            r_disp   <= 1'b0;
            r_solved <= 1'b0;
            r_hex    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_tgt    <= w_tgt_nxt;
            r_idx    <= w_idx_nxt;
            r_miss   <= w_miss_nxt;
            r_cool   <= w_cool_nxt;
            r_disp   <= w_disp_nxt;
            r_solved <= w_solved_nxt;
            r_hex    <= w_hex_nxt;
        end
    end

    assign bus.ext_Disp_On   = r_disp;
    assign bus.hex_Num_Sel   = r_hex;
    assign bus.digit_Idx     = r_idx;
    assign bus.miss_Cnt      = r_miss;
    assign bus.puzzle_Solved = r_solved;
endmodule

// File: tb/tb_hex_seq_game.sv
// tb/tb_hex_seq_game.sv - directed self-checking bench for hex_seq_game
module tb_hex_seq_game;
    localparam logic [31:0] SEED = 32'hACE1_5EED;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] m_lfsr;
    logic [31:0] exp_t;

    hex_seq_game_if #(.N_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

    hex_seq_game #(
        .N_DIGITS(4), .DIGIT_W(4), .LFSR_W(32), .SEED(SEED),
        .MAX_TRIES(3), .COOLDOWN_S(60)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
    end

    function automatic logic [3:0] dig(input logic [31:0] l, input int k);
        logic [3:0] d;
        d = l[k*4 +: 4];
        return (d == 4'h0) ? 4'hF : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp"},   32'(bus.ext_Disp_On),   32'h0);
        chk({tag, "_hex"},    32'(bus.hex_Num_Sel),   32'h0);
        chk({tag, "_idx"},    32'(bus.digit_Idx),     32'h0);
        chk({tag, "_miss"},   32'(bus.miss_Cnt),      32'h0);
        chk({tag, "_solved"}, 32'(bus.puzzle_Solved), 32'h0);
    endtask

    initial begin
        bus.game_Ena    = 1'b0;
        bus.user_Inp    = 4'h0;
        bus.enter_Pulse = 1'b0;
        bus.tick_1Hz    = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_disp", 32'(bus.ext_Disp_On), 32'h0);

        // Arm and solve the first puzzle.
        bus.game_Ena = 1'b1;
        exp_t = m_lfsr;
        step();
        chk("arm_disp", 32'(bus.ext_Disp_On), 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("solve_idx%0d", k), 32'(bus.digit_Idx), 32'(k));
            chk($sformatf("solve_hex%0d", k), 32'(bus.hex_Num_Sel), 32'(dig(exp_t, k)));
            bus.user_Inp    = dig(exp_t, k);
            bus.enter_Pulse = 1'b1;
            step();
            bus.enter_Pulse = 1'b0;
        end
        chk("solved_flag", 32'(bus.puzzle_Solved), 32'h1);
        chk("solved_disp", 32'(bus.ext_Disp_On), 32'h0);

        // Cooldown with game_Ena held high, then automatic re-arm.
        for (int i = 1; i <= 60; i++) begin
            bus.tick_1Hz = 1'b1;
            step();
            bus.tick_1Hz = 1'b0;
            if (i < 60) begin
                if (i == 1 || i == 59)
                    chk($sformatf("cool_hold%0d", i), 32'(bus.puzzle_Solved), 32'h1);
                step();
            end
        end
        chk("cool_done_solved", 32'(bus.puzzle_Solved), 32'h0);
        chk("cool_done_disp", 32'(bus.ext_Disp_On), 32'h0);
        exp_t = m_lfsr;
        step();
        chk("rearm_disp", 32'(bus.ext_Disp_On), 32'h1);
        chk("rearm_hex", 32'(bus.hex_Num_Sel), 32'(dig(exp_t, 0)));

        // Two correct digits, then a wrong one.
        for (int k = 0; k < 2; k++) begin
            bus.user_Inp    = dig(exp_t, k);
            bus.enter_Pulse = 1'b1;
            step();
            bus.enter_Pulse = 1'b0;
        end
        chk("pre_miss_idx", 32'(bus.digit_Idx), 32'h2);
        bus.user_Inp    = dig(exp_t, 2) ^ 4'h1;
        bus.enter_Pulse = 1'b1;
        step();
        bus.enter_Pulse = 1'b0;
        chk("miss1_idx", 32'(bus.digit_Idx), 32'h0);
        chk("miss1_cnt", 32'(bus.miss_Cnt), 32'h1);
        chk("miss1_hex", 32'(bus.hex_Num_Sel), 32'(dig(exp_t, 0)));

        bus.user_Inp    = dig(exp_t, 0) ^ 4'h1;
        bus.enter_Pulse = 1'b1;
        step();
        chk("miss2_cnt", 32'(bus.miss_Cnt), 32'h2);
`ifdef HEX_SEQ_GAME_RESEED_EN
        exp_t = m_lfsr;
        step();
        bus.enter_Pulse = 1'b0;
        chk("reseed_cnt", 32'(bus.miss_Cnt), 32'h0);
        chk("reseed_hex", 32'(bus.hex_Num_Sel), 32'(dig(exp_t, 0)));
`else
        step();
        chk("miss3_cnt", 32'(bus.miss_Cnt), 32'h3);
        chk("miss3_hex", 32'(bus.hex_Num_Sel), 32'(dig(exp_t, 0)));
        step();
        bus.enter_Pulse = 1'b0;
        chk("miss_sat_cnt", 32'(bus.miss_Cnt), 32'h3);
        chk("miss_sat_hex", 32'(bus.hex_Num_Sel), 32'(dig(exp_t, 0)));
`endif

        // Asynchronous reset mid-PLAY.
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #2 rst = 1'b0;
        exp_t = m_lfsr;
        chk("rst_model_seed", exp_t, SEED);
        step();
        chk("post_rst_disp", 32'(bus.ext_Disp_On), 32'h1);
        chk("post_rst_hex", 32'(bus.hex_Num_Sel), 32'(dig(SEED, 0)));

        // game_Ena drops together with the final correct confirm.
        for (int k = 0; k < 4; k++) begin
            bus.user_Inp    = dig(SEED, k);
            bus.enter_Pulse = 1'b1;
            if (k == 3) bus.game_Ena = 1'b0;
            step();
            bus.enter_Pulse = 1'b0;
        end
        chk("drop_solved", 32'(bus.puzzle_Solved), 32'h0);
        chk("drop_disp", 32'(bus.ext_Disp_On), 32'h0);
        step();
        chk("drop_solved_hold", 32'(bus.puzzle_Solved), 32'h0);

        // Confirms in IDLE are ignored.
        bus.user_Inp    = 4'h0;
        bus.enter_Pulse = 1'b1;
        step();
        bus.enter_Pulse = 1'b0;
        step();
        chk("idle_enter_miss", 32'(bus.miss_Cnt), 32'h0);
        chk("idle_enter_disp", 32'(bus.ext_Disp_On), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
